vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing_pkg.sv | 18 +
 rtl/wrap_counter.sv | 24 ++
 rtl/vga_timing.sv | 78 +++++++
 tb/tb_vga_timing.sv | 98 +++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants and the per-axis timing struct.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } timing_t;

    localparam timing_t VGA_H = '{640, 16, 96, 48};
    localparam timing_t VGA_V = '{480, 10, 2, 33};

    function automatic int unsigned total(timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: 0..MAX counter advancing on inc, with a combinational carry at MAX.
module wrap_counter #(
    parameter int MAX = 7
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         inc,
    output logic [$clog2(MAX+1)-1:0]     count,
    output logic                         wrap
);

    localparam int W = $clog2(MAX + 1);

    assign wrap = inc && count == W'(MAX);

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            count <= '0;
        else if (wrap)
            count <= '0;
        else if (inc)
            count <= count + W'(1);

endmodule

// File: rtl/vga_timing.sv
// vga_timing: raster counters with registered sync/active/start strobes aligned to x,y.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = int'(VGA_H.active),
    parameter int H_FP     = int'(VGA_H.fp),
    parameter int H_SYNC   = int'(VGA_H.sync),
    parameter int H_BP     = int'(VGA_H.bp),
    parameter int V_ACTIVE = int'(VGA_V.active),
    parameter int V_FP     = int'(VGA_V.fp),
    parameter int V_SYNC   = int'(VGA_V.sync),
    parameter int V_BP     = int'(VGA_V.bp),
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          enable,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          line_start,
    output logic          frame_start
);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        (HS_POL != 0 && HS_POL != 1) || (VS_POL != 0 && VS_POL != 1)) begin : g_bad_params
        $error("vga_timing: timing parameters must be >= 1 and polarities 0 or 1");
    end

    localparam logic [XW-1:0] XA  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS0 = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS1 = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] YA  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS0 = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS1 = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HP  = HS_POL[0];
    localparam logic          VP  = VS_POL[0];

    logic          xw, yw;
    logic [XW-1:0] xn;
    logic [YW-1:0] yn;

    wrap_counter #(.MAX(H_TOTAL - 1)) u_x (
        .clock(clock), .reset_n(reset_n), .inc(enable), .count(x), .wrap(xw)
    );

    wrap_counter #(.MAX(V_TOTAL - 1)) u_y (
        .clock(clock), .reset_n(reset_n), .inc(xw), .count(y), .wrap(yw)
    );

    // Decode from the counters' next values so the registered flags line up with x,y.
    assign xn = xw ? '0 : x + XW'(enable);
    assign yn = yw ? '0 : y + YW'(xw);

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            active      <= 1'b1;
            hsync       <= ~HP;
            vsync       <= ~VP;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            active      <= xn < XA && yn < YA;
            hsync       <= (xn >= HS0 && xn < HS1) ? HP : ~HP;
            vsync       <= (yn >= VS0 && yn < VS1) ? VP : ~VP;
            line_start  <= xw;
            frame_start <= yw;
        end

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: random-enable stimulus against a pixel-count model of an 8x6 raster.
module tb_vga_timing;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] x;
    logic [2:0] y;
    logic       hsync, vsync, active, line_start, frame_start;

    int checks = 0;
    int failures = 0;
    int n = 0;
    int fs_count;

    vga_timing #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .x(x), .y(y), .hsync(hsync), .vsync(vsync), .active(active),
        .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (n=%0d t=%0t)", tag, got, exp, n, $time);
        end
    endtask

    // n counts enabled pixels since reset; the raster position follows from it directly.
    task automatic check_all(input int ls, input int fs);
        int ex, ey;
        ex = n % 8;
        ey = (n / 8) % 6;
        chk("x", 32'(x), ex);
        chk("y", 32'(y), ey);
        chk("active", 32'(active), int'(ex < 4 && ey < 3));
        chk("hsync", 32'(hsync), int'(!(ex >= 5 && ex < 7)));
        chk("vsync", 32'(vsync), int'(ey >= 4 && ey < 5));
        chk("line_start", 32'(line_start), ls);
        chk("frame_start", 32'(frame_start), fs);
    endtask

    task automatic cyc(input logic en);
        enable = en;
        @(posedge clock);
        #1;
        if (reset_n && en)
            n++;
        check_all(int'(reset_n && en && n % 8 == 0), int'(reset_n && en && n % 48 == 0));
    endtask

    initial begin
        repeat (3) cyc(1'($urandom_range(0, 1)));
        reset_n = 1'b1;
        fs_count = 0;
        repeat (48) begin
            cyc(1'b1);
            fs_count += 32'(frame_start);
        end
        chk("frame_start_once_per_48", fs_count, 1);
        repeat (20) begin
            cyc(1'b1);
            cyc(1'b0);
            cyc(1'b0);
            cyc(1'b1);
        end
        repeat (300) cyc(1'($urandom_range(0, 1)));
        reset_n = 1'b0;
        n = 0;
        cyc(1'b0);
        reset_n = 1'b1;
        repeat (22) cyc(1'b1);
        #2;
        reset_n = 1'b0;
        n = 0;
        #1;
        check_all(0, 0);
        cyc(1'b1);
        cyc(1'b1);
        reset_n = 1'b1;
        fs_count = 0;
        repeat (10) begin
            cyc(1'b1);
            fs_count += 32'(frame_start);
        end
        chk("no_frame_start_after_reset", fs_count, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
